// File: rtl/xosera_pkg.sv
// -----------------------------------------------------------------------------
// xosera_pkg
// Shared constants for the audio ADC receiver. The defaults below are the
// widths the audio_adc_rx top picks up when instantiated without overrides.
//   AUDIO_ADC_WIDTH      : output sample width in bits
//   AUDIO_ADC_DECIM_LOG2 : log2 of the decimation window length in clocks
// -----------------------------------------------------------------------------
package xosera_pkg;

   localparam int AUDIO_ADC_WIDTH      = 8;
   localparam int AUDIO_ADC_DECIM_LOG2 = 8;

endpackage : xosera_pkg

// File: rtl/audio_adc_sync.sv
// -----------------------------------------------------------------------------
// audio_adc_sync
// Two-flop synchronizer that brings the asynchronous comparator output into
// the clk domain.
// Ports:
//   clk     : rising-edge clock
//   reset_i : asynchronous active-high reset, clears both flops
//   d_i     : asynchronous 1-bit input
//   q_o     : synchronized output, two clocks behind d_i
// -----------------------------------------------------------------------------
module audio_adc_sync
   import xosera_pkg::*;
(
   input  logic clk,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule : audio_adc_sync

// File: rtl/audio_adc_rx.sv
// -----------------------------------------------------------------------------
// audio_adc_rx
// Receiver for an external RC sigma-delta ADC. The comparator bit is
// synchronized, fed straight back as the integrator drive, and counted over a
// 2^DECIM_LOG2-clock window. The ones count, clipped to the window maximum and
// scaled to WIDTH bits, is presented with a valid/ready handshake and a
// sticky overrun flag. DECIM_LOG2 must be >= WIDTH.
// Ports:
//   clk           : rising-edge clock
//   reset_i       : asynchronous active-high reset
//   pdm_i         : comparator output (asynchronous to clk)
//   fb_o          : feedback drive to the RC integrator (synchronized pdm_i)
//   enable_i      : high lets the decimation window advance
//   sample_o      : latest decimated sample, unsigned
//   valid_o       : sample_o holds an unconsumed sample
//   ready_i       : consumer accepts sample_o this cycle
//   overrun_o     : sticky, an unconsumed sample was overwritten
//   overrun_clr_i : one-cycle pulse clears overrun_o
// -----------------------------------------------------------------------------
module audio_adc_rx
   import xosera_pkg::*;
#(
   parameter int WIDTH      = AUDIO_ADC_WIDTH,
   parameter int DECIM_LOG2 = AUDIO_ADC_DECIM_LOG2
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             pdm_i,
   output logic             fb_o,
   input  logic             enable_i,
   output logic [WIDTH-1:0] sample_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             overrun_o,
   input  logic             overrun_clr_i
);

   localparam logic [DECIM_LOG2-1:0] WIN_LAST = '1;
   localparam logic [DECIM_LOG2-1:0] WIN_ONE  = DECIM_LOG2'(1);

   // An all-ones window counts 2^DECIM_LOG2, one past what DECIM_LOG2 bits
   // hold; clip it to all-ones so it never wraps to zero, then keep the top
   // WIDTH bits as the scaled sample.
   function automatic logic [WIDTH-1:0] sat_scale(input logic [DECIM_LOG2:0] total);
      logic [DECIM_LOG2-1:0] clip;
      clip = total[DECIM_LOG2] ? '1 : total[DECIM_LOG2-1:0];
      return clip[DECIM_LOG2-1 -: WIDTH];
   endfunction

   logic                  s2;
   logic                  win_end;
   logic [DECIM_LOG2:0]   total;

   logic [DECIM_LOG2-1:0] win_q,     win_d;
   logic [DECIM_LOG2:0]   acc_q,     acc_d;
   logic [WIDTH-1:0]      sample_q,  sample_d;
   logic                  valid_q,   valid_d;
   logic                  overrun_q, overrun_d;

   audio_adc_sync u_sync (
      .clk     (clk),
      .reset_i (reset_i),
      .d_i     (pdm_i),
      .q_o     (s2)
   );

   assign win_end = enable_i && (win_q == WIN_LAST);
   // The final bit of the window is folded in here rather than through the
   // accumulator so the sample can load on the same edge that clears it.
   assign total   = acc_q + {{DECIM_LOG2{1'b0}}, s2};

   always_comb begin
      win_d     = win_q;
      acc_d     = acc_q;
      sample_d  = sample_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      if (enable_i) begin
         win_d = win_q + WIN_ONE;
         acc_d = win_end ? '0 : total;
      end

      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      if (overrun_clr_i) begin
         overrun_d = 1'b0;
      end

      // A load overrides the handshake clear and the overrun clear; it only
      // counts as an overrun if the old sample is not being taken this cycle.
      if (win_end) begin
         sample_d = sat_scale(total);
         valid_d  = 1'b1;
         if (valid_q && !ready_i) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         win_q     <= '0;
         acc_q     <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         win_q     <= win_d;
         acc_q     <= acc_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign fb_o      = s2;
   assign sample_o  = sample_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;

endmodule : audio_adc_rx

// File: tb/tb_audio_adc_rx.sv
module tb_audio_adc_rx;

   logic       clk = 1'b0;
   logic       reset_i;
   logic       pdm_i;
   logic       fb_o;
   logic       enable_i;
   logic [7:0] sample_o;
   logic       valid_o;
   logic       ready_i;
   logic       overrun_o;
   logic       overrun_clr_i;

   logic       pdm_lvl;
   logic       alt_on;
   logic       alt_bit = 1'b0;

   // second instance, DECIM_LOG2=10, fed a 1-of-4 pattern
   logic       rst2;
   logic       pdm2;
   logic       fb2;
   logic [7:0] sample2;
   logic       valid2;
   logic       ovr2;
   logic [1:0] ph4 = 2'd0;
   logic [7:0] last2 = 8'h00;
   int         n2 = 0;

   int n_vec = 0;
   int n_err = 0;
   int n;

   always #5 clk = ~clk;

   assign pdm_i = alt_on ? alt_bit : pdm_lvl;
   assign pdm2  = (ph4 == 2'd0);

   audio_adc_rx dut (
      .clk           (clk),
      .reset_i       (reset_i),
      .pdm_i         (pdm_i),
      .fb_o          (fb_o),
      .enable_i      (enable_i),
      .sample_o      (sample_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .overrun_o     (overrun_o),
      .overrun_clr_i (overrun_clr_i)
   );

   audio_adc_rx #(.WIDTH(8), .DECIM_LOG2(10)) dut10 (
      .clk           (clk),
      .reset_i       (rst2),
      .pdm_i         (pdm2),
      .fb_o          (fb2),
      .enable_i      (1'b1),
      .sample_o      (sample2),
      .valid_o       (valid2),
      .ready_i       (1'b1),
      .overrun_o     (ovr2),
      .overrun_clr_i (1'b0)
   );

   initial begin
      forever begin
         @(posedge clk);
         #1;
         alt_bit = ~alt_bit;
         ph4     = ph4 + 2'd1;
         if (valid2) begin
            last2 = sample2;
            n2    = n2 + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int cnt);
      repeat (cnt) begin
         @(posedge clk);
         #1;
      end
   endtask

   // returns number of edges until valid_o is seen (capped at max)
   task automatic wait_valid(input int max, output int cnt);
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt = cnt + 1;
      end while (!valid_o && cnt < max);
   endtask

   initial begin
      reset_i       = 1'b1;
      rst2          = 1'b1;
      pdm_lvl       = 1'b0;
      alt_on        = 1'b0;
      enable_i      = 1'b1;
      ready_i       = 1'b1;
      overrun_clr_i = 1'b0;
      #2;
      chk("rst_sample",  {24'd0, sample_o}, 32'h00);
      chk("rst_valid",   {31'd0, valid_o},   32'd0);
      chk("rst_overrun", {31'd0, overrun_o}, 32'd0);
      chk("rst_fb",      {31'd0, fb_o},      32'd0);

      @(posedge clk);
      #1;
      reset_i = 1'b0;
      rst2    = 1'b0;

      // pdm held 0
      wait_valid(300, n);
      chk("zero_lat1",    n, 256);
      chk("zero_sample1", {24'd0, sample_o}, 32'h00);
      chk("zero_fb",      {31'd0, fb_o}, 32'd0);
      wait_valid(300, n);
      chk("zero_lat2",    n, 256);
      chk("zero_sample2", {24'd0, sample_o}, 32'h00);
      tick(1);
      chk("hs_clear", {31'd0, valid_o}, 32'd0);

      // overrun: window A all zeros, window B all ones, ready low
      ready_i = 1'b0;
      tick(253);
      pdm_lvl = 1'b1;
      tick(1);
      chk("fb_rise_1clk", {31'd0, fb_o}, 32'd0);
      tick(1);
      chk("fb_rise_2clk", {31'd0, fb_o}, 32'd1);
      chk("ovA_valid",    {31'd0, valid_o}, 32'd1);
      chk("ovA_sample",   {24'd0, sample_o}, 32'h00);
      chk("ovA_overrun",  {31'd0, overrun_o}, 32'd0);
      tick(256);
      chk("ovB_sample",   {24'd0, sample_o}, 32'hFF);
      chk("ovB_valid",    {31'd0, valid_o}, 32'd1);
      chk("ovB_overrun",  {31'd0, overrun_o}, 32'd1);
      overrun_clr_i = 1'b1;
      tick(1);
      overrun_clr_i = 1'b0;
      chk("ovclr_overrun", {31'd0, overrun_o}, 32'd0);
      chk("ovclr_valid",   {31'd0, valid_o}, 32'd1);
      chk("ovclr_sample",  {24'd0, sample_o}, 32'hFF);
      ready_i = 1'b1;
      tick(1);
      chk("ov_consume", {31'd0, valid_o}, 32'd0);

      // full ones window saturates
      wait_valid(300, n);
      chk("ones_lat",    n, 254);
      chk("ones_sample", {24'd0, sample_o}, 32'hFF);

      // load coinciding with handshake: two ones still in the pipe -> 0x02
      pdm_lvl = 1'b0;
      ready_i = 1'b0;
      tick(255);
      chk("hold_valid", {31'd0, valid_o}, 32'd1);
      ready_i = 1'b1;
      tick(1);
      chk("hsld_valid",   {31'd0, valid_o}, 32'd1);
      chk("hsld_sample",  {24'd0, sample_o}, 32'h02);
      chk("hsld_overrun", {31'd0, overrun_o}, 32'd0);
      tick(1);
      chk("hsld_clear",   {31'd0, valid_o}, 32'd0);

      // alternating pattern -> 0x80
      alt_on = 1'b1;
      wait_valid(300, n);
      chk("alt_lat1", n, 255);
      wait_valid(300, n);
      chk("alt_lat2",    n, 256);
      chk("alt_sample2", {24'd0, sample_o}, 32'h80);

      // enable pause of 100 clocks mid-window
      tick(50);
      enable_i = 1'b0;
      tick(100);
      chk("pause_valid",  {31'd0, valid_o}, 32'd0);
      chk("pause_sample", {24'd0, sample_o}, 32'h80);
      enable_i = 1'b1;
      wait_valid(300, n);
      chk("pause_lat",    n + 150, 356);
      chk("pause_sample2", {24'd0, sample_o}, 32'h80);

      // asynchronous reset mid-window
      alt_on  = 1'b0;
      pdm_lvl = 1'b1;
      tick(100);
      reset_i = 1'b1;
      #1;
      chk("arst_sample",  {24'd0, sample_o}, 32'h00);
      chk("arst_valid",   {31'd0, valid_o}, 32'd0);
      chk("arst_overrun", {31'd0, overrun_o}, 32'd0);
      chk("arst_fb",      {31'd0, fb_o}, 32'd0);
      #1;
      reset_i = 1'b0;
      wait_valid(300, n);
      chk("arst_lat",    n, 256);
      chk("arst_sample1", {24'd0, sample_o}, 32'hFE);
      wait_valid(300, n);
      chk("arst_sample2", {24'd0, sample_o}, 32'hFF);

      // DECIM_LOG2=10 instance, 1-of-4 ones
      chk("d10_windows", {31'd0, (n2 >= 2)}, 32'd1);
      chk("d10_sample",  {24'd0, last2}, 32'h40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_audio_adc_rx

// File: doc/audio_adc_rx.md
AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the output sample width in bits.
REQ-002 SHALL have parameter DECIM_LOG2, default 8, giving log2 of the decimation window in clocks; DECIM_LOG2 >= WIDTH is required.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pdm_i, input, 1 bit: comparator output of the external RC sigma-delta loop; asynchronous to clk.
REQ-006 SHALL have port fb_o, output, 1 bit: feedback drive to the RC integrator.
REQ-007 SHALL have port enable_i, input, 1 bit: high lets decimation run.
REQ-008 SHALL have port sample_o, output, WIDTH bits: latest decimated sample, unsigned.
REQ-009 SHALL have port valid_o, output, 1 bit: sample_o holds an unconsumed sample.
REQ-010 SHALL have port ready_i, input, 1 bit: the consumer accepts sample_o.
REQ-011 SHALL have port overrun_o, output, 1 bit: sticky flag; an unconsumed sample was overwritten.
REQ-012 SHALL have port overrun_clr_i, input, 1 bit: a one-cycle pulse clears overrun_o.

Function
REQ-013 SHALL pass pdm_i through two flops (s1, s2); fb_o SHALL equal s2, so latency from pdm_i to fb_o is 2 clocks.
REQ-014 SHALL keep a window counter of DECIM_LOG2 bits that counts 0 to 2^DECIM_LOG2-1 and wraps, advancing only while enable_i=1.
REQ-015 SHALL keep a ones accumulator of DECIM_LOG2+1 bits that adds s2 on each enabled cycle.
REQ-016 On an enabled cycle where the window counter is at its maximum, SHALL form total = accumulator + s2 and, on the next edge, load sample_o with min(total, 2^DECIM_LOG2-1) >> (DECIM_LOG2-WIDTH), clear the accumulator, and set valid_o=1.
REQ-017 Saturation SHALL map an all-ones window (total = 2^DECIM_LOG2) to sample_o all-ones, with no wrap to zero.
REQ-018 With enable_i=0, the window counter and accumulator SHALL hold; the synchronizer, fb_o and the handshake logic SHALL keep running; re-enable SHALL resume the window without restarting it.
REQ-019 valid_o SHALL clear on the edge after a cycle with valid_o=1 and ready_i=1, unless a new sample loads on that same edge.
REQ-020 If a sample loads on the same edge as a handshake (valid_o=1, ready_i=1), valid_o SHALL stay 1, sample_o SHALL update, and overrun_o SHALL NOT set.
REQ-021 If a sample loads while valid_o=1 and ready_i=0, sample_o SHALL be overwritten and overrun_o SHALL set.
REQ-022 overrun_clr_i SHALL clear overrun_o on the next edge; a same-cycle overrun set SHALL win.
REQ-023 sample_o SHALL change only on a sample load; it SHALL be stable while valid_o=1 and no load occurs.

Reset
REQ-024 Asserting reset_i SHALL immediately, without a clock edge, drive s1, s2, fb_o, the window counter, the accumulator, sample_o, valid_o and overrun_o to 0.
REQ-025 Reset in mid-window SHALL discard the partial window; after release, the first sample SHALL cover a full 2^DECIM_LOG2 enabled cycles.

Structure
REQ-026 The package xosera_pkg SHALL hold the defaults AUDIO_ADC_WIDTH=8 and AUDIO_ADC_DECIM_LOG2=8, which the instantiating top uses.
REQ-027 The two-flop synchronizer SHALL be a sub-module audio_adc_sync (1-bit data, clk, reset_i); decimation and handshake logic SHALL live in audio_adc_rx.

Verification (WIDTH=8, DECIM_LOG2=8, enable_i=1, ready_i=1 unless noted)
REQ-028 pdm_i held 0 -> a valid_o pulse every 256 clocks with sample_o=0x00; fb_o=0.
REQ-029 pdm_i held 1 -> sample_o=0xFF (saturated, not 0x00) every 256 clocks; fb_o=1 two clocks after pdm_i rises.
REQ-030 pdm_i alternating 1,0 -> sample_o=0x80; with DECIM_LOG2=10 and 1-of-4 ones -> sample_o=0x40.
REQ-031 ready_i=0 across two window ends (first window all 0, second all 1) -> sample_o=0xFF, valid_o=1, overrun_o=1; an overrun_clr_i pulse -> overrun_o=0; ready_i pulse -> valid_o=0.
REQ-032 enable_i=0 for 100 clocks mid-window -> the next valid_o arrives 356 clocks after window start with an unchanged value; reset_i pulsed mid-window -> all outputs 0 with no clock edge, next valid_o 256 enabled clocks after release.
